display_arbiter: RTL and testbench

Time-shares the single 4-digit seven-segment display between three content sources: player-1 score, player-2 score and an alert page (e.g. game over or hit). The two score pages rotate round-robin with a fixed dwell time. The alert page preempts both and is held for a minimum time. The block sits between game logic and the digit-scan driver, and feeds it a registered 16-bit hex value plus a per-digit blank mask with leading zeros suppressed.

---
 rtl/disp_pkg.sv | 37 +++
 rtl/display_lz_blank.sv | 21 ++
 rtl/display_arbiter.sv | 166 ++++++++++++++++
 tb/tb_display_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter and its helpers.
// Holds the FSM state enum, source indices, blank mask and round-robin pick.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_ALERT
    } state_e;

    localparam logic [1:0] SRC_P1    = 2'd0;
    localparam logic [1:0] SRC_P2    = 2'd1;
    localparam logic [1:0] SRC_ALERT = 2'd2;

    localparam logic [3:0] BLANK_ALL = 4'b1111;

    typedef struct packed {
        logic       vld;
        logic [1:0] src;
    } pick_t;

    // First requesting score source, searching from the round-robin pointer.
    function automatic pick_t pick_score(input logic [1:0] r, input logic rr);
        pick_t p;
        p.vld = 1'b0;
        p.src = SRC_P1;
        if (r[rr]) begin
            p.vld = 1'b1;
            p.src = {1'b0, rr};
        end else if (r[~rr]) begin
            p.vld = 1'b1;
            p.src = {1'b0, ~rr};
        end
        return p;
    endfunction

endpackage

// File: rtl/display_lz_blank.sv
// Leading-zero blank mask for a 4-digit hex display (1 = digit dark).
// Ports: value (16-bit, digit 0 = [3:0]) in; blank (4-bit) out.
module display_lz_blank #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic [15:0] value,
    output logic [3:0]  blank
);

    always_comb begin
        blank = 4'b0000;
        if (BLANK_LZ) begin
            blank[3] = (value[15:12] == 4'h0);
            blank[2] = (value[15:8]  == 8'h00);
            blank[1] = (value[15:4]  == 12'h000);
            // Digit 0 always lit so a zero value shows a single "0".
            blank[0] = 1'b0;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Time-shares a 4-digit display between two score pages and an alert page.
// Ports: clk, rst (sync, active-high), req[2:0], value0..2 in;
//        gnt, disp_value, disp_blank, done out (all registered).
module display_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned ALERT_HOLD   = 100_000_000,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] value0,
    input  logic [15:0] value1,
    input  logic [15:0] value2,
    output logic [2:0]  gnt,
    output logic [15:0] disp_value,
    output logic [3:0]  disp_blank,
    output logic [2:0]  done
);

    localparam int unsigned CNT_MAX =
        (DWELL_CYCLES > ALERT_HOLD) ? DWELL_CYCLES : ALERT_HOLD;
    localparam int unsigned CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] ALERT_LAST = CW'(ALERT_HOLD - 1);

    state_e        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [15:0]   val_q, val_d;
    logic [3:0]    blank_q, blank_d;
    logic [2:0]    done_q, done_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    pick_t       idle_pick;
    logic        nxt_vld;
    logic [1:0]  nxt_src;
    logic [1:0]  cur_src;
    logic [1:0]  oth_src;
    logic [15:0] sel_val;
    logic [3:0]  lz_mask;

    assign cur_src = gnt_q[1] ? SRC_P2 : SRC_P1;
    assign oth_src = gnt_q[1] ? SRC_P1 : SRC_P2;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        done_d    = 3'b000;
        nxt_vld   = 1'b0;
        nxt_src   = SRC_P1;
        idle_pick = pick_score(req[1:0], rr_q);
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req[SRC_ALERT]) begin
                    state_d = ST_ALERT;
                    nxt_vld = 1'b1;
                    nxt_src = SRC_ALERT;
                end else if (idle_pick.vld) begin
                    state_d = ST_SHOW;
                    nxt_vld = 1'b1;
                    nxt_src = idle_pick.src;
                end
            end
            ST_SHOW: begin
                nxt_vld = 1'b1;
                nxt_src = cur_src;
                cnt_d   = cnt_q + CW'(1);
                if (req[SRC_ALERT]) begin
                    state_d = ST_ALERT;
                    nxt_src = SRC_ALERT;
                    cnt_d   = '0;
                end else if (!req[cur_src]) begin
                    cnt_d = '0;
                    if (req[oth_src]) begin
                        nxt_src = oth_src;
                    end else begin
                        state_d = ST_IDLE;
                        nxt_vld = 1'b0;
                    end
                end else if (cnt_q == DWELL_LAST) begin
                    done_d[cur_src] = 1'b1;
                    rr_d  = oth_src[0];
                    cnt_d = '0;
                    if (req[oth_src]) begin
                        nxt_src = oth_src;
                    end
                end
            end
            ST_ALERT: begin
                nxt_vld = 1'b1;
                nxt_src = SRC_ALERT;
                if (cnt_q != ALERT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!req[SRC_ALERT]) begin
                    done_d[SRC_ALERT] = 1'b1;
                    cnt_d = '0;
                    if (idle_pick.vld) begin
                        state_d = ST_SHOW;
                        nxt_src = idle_pick.src;
                    end else begin
                        state_d = ST_IDLE;
                        nxt_vld = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sel_val = value0;
        unique case (nxt_src)
            SRC_P1:    sel_val = value0;
            SRC_P2:    sel_val = value1;
            SRC_ALERT: sel_val = value2;
            default:   sel_val = value0;
        endcase
    end

    display_lz_blank #(
        .BLANK_LZ (BLANK_LZ)
    ) u_lz (
        .value (sel_val),
        .blank (lz_mask)
    );

    always_comb begin
        gnt_d   = nxt_vld ? (3'b001 << nxt_src) : 3'b000;
        val_d   = nxt_vld ? sel_val : 16'h0000;
        blank_d = nxt_vld ? lz_mask : BLANK_ALL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 3'b000;
            val_q   <= 16'h0000;
            blank_q <= BLANK_ALL;
            done_q  <= 3'b000;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            val_q   <= val_d;
            blank_q <= blank_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign disp_value = val_q;
    assign disp_blank = blank_q;
    assign done       = done_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter (DWELL_CYCLES=8, ALERT_HOLD=5).
// Reference model predicts each registered output; DUT output is popped and compared.
module tb_display_arbiter;

    localparam int D = 8;
    localparam int H = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [15:0] value0 = 16'h0, value1 = 16'h0, value2 = 16'h0;
    logic [2:0]  gnt;
    logic [15:0] disp_value;
    logic [3:0]  disp_blank;
    logic [2:0]  done;

    display_arbiter #(
        .DWELL_CYCLES (D),
        .ALERT_HOLD   (H),
        .BLANK_LZ     (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .value0     (value0),
        .value1     (value1),
        .value2     (value2),
        .gnt        (gnt),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  gnt;
        logic [15:0] val;
        logic [3:0]  blank;
        logic [2:0]  done;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state: 0 idle, 1 score page, 2 alert; m_left = cycles still owed.
    int m_state = 0;
    int m_src   = 0;
    int m_rr    = 0;
    int m_left  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_blank(input logic [15:0] v);
        logic [3:0] b;
        bit lead;
        b = 4'b0000;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (v[i*4 +: 4] != 4'h0) lead = 1'b0;
            b[i] = lead;
        end
        return b;
    endfunction

    function automatic int first_score(input logic [2:0] r, input int rr);
        if (r[rr]) return rr;
        if (r[1-rr]) return 1 - rr;
        return -1;
    endfunction

    task automatic model_edge(output obs_t e);
        int nsrc;
        int f;
        bit fresh;
        logic [2:0] dn;
        logic [15:0] v;
        dn = 3'b000;
        nsrc = -1;
        fresh = 1'b1;
        if (rst) begin
            m_state = 0;
            m_rr = 0;
            m_left = 0;
        end else begin
            f = first_score(req, m_rr);
            case (m_state)
                0: nsrc = req[2] ? 2 : f;
                1: begin
                    if (req[2]) nsrc = 2;
                    else if (!req[m_src]) nsrc = req[1-m_src] ? 1 - m_src : -1;
                    else if (m_left == 1) begin
                        dn[m_src] = 1'b1;
                        m_rr = 1 - m_src;
                        nsrc = req[1-m_src] ? 1 - m_src : m_src;
                    end else begin
                        nsrc = m_src;
                        fresh = 1'b0;
                        m_left--;
                    end
                end
                default: begin
                    if (m_left == 1 && !req[2]) begin
                        dn[2] = 1'b1;
                        nsrc = f;
                    end else begin
                        nsrc = 2;
                        fresh = 1'b0;
                        if (m_left > 1) m_left--;
                    end
                end
            endcase
            if (fresh && nsrc >= 0) m_left = (nsrc == 2) ? H : D;
        end
        m_state = (nsrc < 0) ? 0 : (nsrc == 2) ? 2 : 1;
        if (nsrc >= 0) m_src = nsrc;
        v = (nsrc == 0) ? value0 : (nsrc == 1) ? value1 : value2;
        if (nsrc < 0) begin
            e.gnt = 3'b000;
            e.val = 16'h0000;
            e.blank = 4'b1111;
        end else begin
            e.gnt = 3'b001 << nsrc;
            e.val = v;
            e.blank = ref_blank(v);
        end
        e.done = dn;
    endtask

    task automatic step();
        obs_t e;
        model_edge(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("gnt", 32'(gnt), 32'(e.gnt));
        check_eq("value", 32'(disp_value), 32'(e.val));
        check_eq("blank", 32'(disp_blank), 32'(e.blank));
        check_eq("done", 32'(done), 32'(e.done));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rnd_val();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(3))
            0: r[15:8] = 8'h00;
            1: r[15:4] = 12'h000;
            2: r = 32'h0;
            default: ;
        endcase
        return r[15:0];
    endfunction

    initial begin
        int n0, n1, na, bad;

        // Reset and idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        check_eq("idle_blank", 32'(disp_blank), 32'hf);

        // Rotation
        do_reset();
        value0 = 16'h0042;
        value1 = 16'h1234;
        req = 3'b011;
        n0 = 0; n1 = 0; bad = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) check_eq("rr_tie", 32'(gnt), 32'h1);
            if (gnt == 3'b001 && disp_blank != 4'b1100) bad++;
            if (gnt == 3'b010 && disp_blank != 4'b0000) bad++;
            if (done[0]) n0++;
            if (done[1]) n1++;
        end
        check_eq("rot_blank", 32'(bad), 32'd0);
        check_eq("rot_done0", 32'(n0), 32'd2);
        check_eq("rot_done1", 32'(n1), 32'd2);

        // Single source
        do_reset();
        req = 3'b001;
        n0 = 0; bad = 0;
        for (int i = 1; i <= 33; i++) begin
            step();
            if (gnt != 3'b001) bad++;
            if (done[0]) n0++;
        end
        check_eq("single_gnt", 32'(bad), 32'd0);
        check_eq("single_done", 32'(n0), 32'd4);

        // Preemption at count 3 of source 0
        do_reset();
        value2 = 16'h0000;
        req = 3'b001;
        repeat (4) step();
        req = 3'b101;
        na = 0; n0 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) req = 3'b001;
            step();
            if (i == 0) check_eq("alert_zero_blank", 32'(disp_blank), 32'he);
            if (gnt == 3'b100) na++;
            if (done[0]) n0++;
            if (i == 5) begin
                check_eq("pre_regnt", 32'(gnt), 32'h1);
                check_eq("pre_done2", 32'(done), 32'h4);
            end
        end
        check_eq("pre_len", 32'(na), 32'd5);
        check_eq("pre_nodone0", 32'(n0), 32'd0);

        // Drop mid-dwell
        do_reset();
        req = 3'b011;
        repeat (4) step();
        req = 3'b010;
        step();
        check_eq("drop_gnt", 32'(gnt), 32'h2);
        check_eq("drop_done", 32'(done), 32'h0);

        // Reset during alert
        req = 3'b100;
        repeat (3) step();
        rst = 1'b1;
        step();
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_val", 32'(disp_value), 32'h0);
        check_eq("rst_blank", 32'(disp_blank), 32'hf);
        rst = 1'b0;
        req = 3'b000;
        step();

        // Random traffic with live values
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(29) == 0) req[2] = ~req[2];
            if ($urandom_range(11) == 0) req[0] = ~req[0];
            if ($urandom_range(11) == 0) req[1] = ~req[1];
            value0 = rnd_val();
            value1 = rnd_val();
            value2 = rnd_val();
            rst = ($urandom_range(149) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
